// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit:
// state codes, opcodes and datapath mux select values.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_SEXT    = 2'b10;
    localparam logic [1:0] SRCB_SEXT_SH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mem_timeout.sv
// Memory-wait watchdog: counts consecutive stalled cycles and flags
// expiry on the last allowed cycle so the FSM can abort the access.
module mips_mem_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic ready,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       stall;

    assign stall  = waiting && !ready;
    assign expire = stall && (cnt_q == LAST);

    // Expiry and every state change restart the count from zero.
    always_comb begin
        cnt_d = 8'd0;
        if (stall && !expire)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= 8'd0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with memory-wait stalls,
// memory timeout abort and illegal-opcode recovery.
import mips_ctrl_pkg::*;

module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Instruction_op,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state_dbg
);

    state_t state_q, state_d;
    logic   is_lw_q, is_lw_d;
    logic   waiting;
    logic   expire;

    assign waiting   = (state_q == S_FETCH) || (state_q == S_MEMRD)
                    || (state_q == S_MEMWR);
    assign state_dbg = state_q;

    mips_mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .waiting(waiting),
        .ready  (mem_ready),
        .expire (expire)
    );

    always_comb begin
        state_d     = state_q;
        is_lw_d     = is_lw_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = SRCB_REG;
        ALUOp       = ALU_ADD;
        PCSource    = PC_ALU;
        illegal_op  = 1'b0;
        mem_err     = 1'b0;
        // Under reset every output stays at its zero default.
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = SRCB_FOUR;
                    IRWrite = mem_ready;
                    PCWrite = mem_ready;
                    if (mem_ready)
                        state_d = S_DECODE;
                    else if (expire)
                        mem_err = 1'b1;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_SEXT_SH;
                    is_lw_d = (Instruction_op == OP_LW);
                    case (Instruction_op)
                        OP_RTYPE:     state_d = S_EXEC;
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_BEQ:       state_d = S_BRANCH;
                        OP_J:         state_d = S_JUMP;
                        default: begin
                            state_d    = S_FETCH;
                            illegal_op = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_SEXT;
                    state_d = is_lw_q ? S_MEMRD : S_MEMWR;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEMWB;
                    end else if (expire) begin
                        state_d = S_FETCH;
                        mem_err = 1'b1;
                    end
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                    state_d  = S_FETCH;
                end
                S_MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end else if (expire) begin
                        state_d = S_FETCH;
                        mem_err = 1'b1;
                    end
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = ALU_FUNCT;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = ALU_SUB;
                    PCWriteCond = 1'b1;
                    PCSource    = PC_ALUOUT;
                    state_d     = S_FETCH;
                end
                S_JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = PC_JUMP;
                    state_d  = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            is_lw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_lw_q <= is_lw_d;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected
// control words are queued at drive time and checked on the falling edge.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] RT  = 6'b000000;
    localparam logic [5:0] LW  = 6'b100011;
    localparam logic [5:0] SW  = 6'b101011;
    localparam logic [5:0] BEQ = 6'b000100;
    localparam logic [5:0] JMP = 6'b000010;
    localparam logic [5:0] BAD = 6'b111111;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] Instruction_op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic       illegal_op, mem_err;
    logic [3:0] state_dbg;

    int n_vec = 0;
    int n_bad = 0;

    logic [21:0] expq[$];
    string       tagq[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .Instruction_op(Instruction_op),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .PCWriteCond   (PCWriteCond),
        .IorD          (IorD),
        .MemRead       (MemRead),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .MemtoReg      (MemtoReg),
        .RegDst        (RegDst),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ALUOp         (ALUOp),
        .PCSource      (PCSource),
        .illegal_op    (illegal_op),
        .mem_err       (mem_err),
        .state_dbg     (state_dbg)
    );

    wire [21:0] obs = {state_dbg, PCWrite, PCWriteCond, IorD, MemRead,
                       MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
                       ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, mem_err};

    task automatic check(input string tag, input logic [21:0] got,
                         input logic [21:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected control word for a state, straight from the state table.
    function automatic logic [21:0] model(input logic [3:0] st,
                                          input logic rdy, input logic ill,
                                          input logic merr, input logic rst);
        logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, aop, pcs;
        {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa} = '0;
        asb = 2'b00;
        aop = 2'b00;
        pcs = 2'b00;
        case (st)
            4'd0: begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
            4'd1: asb = 2'b11;
            4'd2: begin asa = 1; asb = 2'b10; end
            4'd3: begin mr = 1; iord = 1; end
            4'd4: begin rw = 1; m2r = 1; end
            4'd5: begin mw = 1; iord = 1; end
            4'd6: begin asa = 1; aop = 2'b10; end
            4'd7: begin rw = 1; rd = 1; end
            4'd8: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9: begin pcw = 1; pcs = 2'b10; end
            default: ;
        endcase
        if (rst)
            return {st, 18'd0};
        return {st, pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa,
                asb, aop, pcs, ill, merr};
    endfunction

    always @(negedge clk) begin
        if (expq.size() != 0)
            check(tagq.pop_front(), obs, expq.pop_front());
    end

    task automatic step(input string tag, input logic [3:0] st,
                        input logic [5:0] op, input logic rdy,
                        input logic ill = 1'b0, input logic merr = 1'b0,
                        input logic rst = 1'b0);
        reset          = rst;
        Instruction_op = op;
        mem_ready      = rdy;
        expq.push_back(model(st, rdy, ill, merr, rst));
        tagq.push_back($sformatf("%s.s%0d", tag, st));
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        // LW interrupted by a 2-cycle reset while waiting in MEMRD
        step("lwrst", 0, LW, 1);
        step("lwrst", 1, LW, 1);
        step("lwrst", 2, LW, 1);
        step("lwrst", 3, LW, 0);
        step("rst",   3, LW, 1, 0, 0, 1);
        step("rst",   0, LW, 1, 0, 0, 1);
        // R-format; first FETCH is also the first post-reset cycle
        step("rtype", 0, RT, 1);
        step("rtype", 1, RT, 1);
        step("rtype", 6, 6'($urandom), 1);
        step("rtype", 7, 6'($urandom), 1);
        // LW, 3 wait cycles, opcode changes to SW after DECODE
        step("lw", 0, LW, 1);
        step("lw", 1, LW, 1);
        step("lw", 2, SW, 1);
        step("lw", 3, SW, 0);
        step("lw", 3, SW, 0);
        step("lw", 3, SW, 0);
        step("lw", 3, SW, 1);
        step("lw", 4, SW, 1);
        // BEQ then J
        step("beq", 0, BEQ, 1);
        step("beq", 1, BEQ, 1);
        step("beq", 8, BEQ, 1);
        step("j", 0, JMP, 1);
        step("j", 1, JMP, 1);
        step("j", 9, JMP, 1);
        // illegal opcodes
        step("ill", 0, BAD, 1);
        step("ill", 1, BAD, 1, 1);
        step("ill2", 0, 6'b001000, 1);
        step("ill2", 1, 6'b001000, 1, 1);
        // SW timeout after 4 stalled cycles, opcode flips to LW after DECODE
        step("swto", 0, SW, 1);
        step("swto", 1, SW, 1);
        step("swto", 2, LW, 1);
        step("swto", 5, LW, 0);
        step("swto", 5, LW, 0);
        step("swto", 5, LW, 0);
        step("swto", 5, LW, 0, 0, 1);
        // SW with mem_ready arriving on the last allowed cycle
        step("swok", 0, SW, 1);
        step("swok", 1, SW, 1);
        step("swok", 2, SW, 1);
        step("swok", 5, SW, 0);
        step("swok", 5, SW, 0);
        step("swok", 5, SW, 0);
        step("swok", 5, SW, 1);
        // FETCH timeout retries the fetch with a fresh count
        step("fto", 0, JMP, 0);
        step("fto", 0, JMP, 0);
        step("fto", 0, JMP, 0);
        step("fto", 0, JMP, 0, 0, 1);
        step("fto", 0, JMP, 0);
        step("fto", 0, JMP, 1);
        step("fto", 1, JMP, 1);
        step("fto", 9, JMP, 1);
        // LW timeout in MEMRD: abort without register write
        step("lwto", 0, LW, 1);
        step("lwto", 1, LW, 1);
        step("lwto", 2, LW, 1);
        step("lwto", 3, LW, 0);
        step("lwto", 3, LW, 0);
        step("lwto", 3, LW, 0);
        step("lwto", 3, LW, 0, 0, 1);
        step("end", 0, RT, 1);
        @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
